conv_window_gen: RTL and testbench

- Streaming 3x3 (parameterised) convolution window generator. It sits directly downstream of the line-buffer ping-pong controller.
- Consumes one vertical column of NUM_LINES pixels per handshake, with an end-of-row marker.
- Shifts columns into a KERNEL_W-deep register and emits a full NUM_LINES x KERNEL_W window per accepted column once enough columns exist in the current row.
- Output feeds the MAC/convolution array through a valid/ready handshake.

---
 rtl/conv_window_gen.sv | 186 ++++++++++++++++++
 tb/tb_conv_window_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// Streaming NUM_LINES x KERNEL_W convolution window generator fed by one pixel column per handshake.
// Define CONV_WINDOW_ZERO_PAD_EN for same-size zero padding (zero preload plus an end-of-row FLUSH).
module conv_window_gen #(
    parameter int NUM_LINES  = 3,
    parameter int KERNEL_W   = 3,
    parameter int DATA_WIDTH = 16,
    parameter int COL_W      = 14
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [NUM_LINES*DATA_WIDTH-1:0]         in_data,
    input  logic                                    in_last,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [NUM_LINES*KERNEL_W*DATA_WIDTH-1:0] out_window,
    output logic [COL_W-1:0]                        out_col,
    output logic                                    out_last
);

    localparam int CW = NUM_LINES * DATA_WIDTH;
    localparam int WW = CW * KERNEL_W;
    localparam int FW = $clog2(KERNEL_W + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(KERNEL_W - 1);

`ifdef CONV_WINDOW_ZERO_PAD_EN
    localparam int P = (KERNEL_W - 1) / 2;
    localparam logic [FW-1:0]    FILL_INIT = FW'(P);
    localparam logic [COL_W-1:0] COL_OFF   = COL_W'(P);
    typedef enum logic [1:0] {S_FILL, S_STREAM, S_FLUSH} state_t;
`else
    localparam logic [FW-1:0]    FILL_INIT = '0;
    localparam logic [COL_W-1:0] COL_OFF   = COL_W'(KERNEL_W - 1);
    typedef enum logic [0:0] {S_FILL, S_STREAM} state_t;
`endif

    typedef logic [CW-1:0] col_t;

    state_t           state_q, state_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [COL_W-1:0] col_idx_q, col_idx_d;
    col_t             col_q [KERNEL_W];
    col_t             col_d [KERNEL_W];
    col_t             shifted [KERNEL_W];
    col_t             shift_in;
    logic [WW-1:0]    win_shift;
    logic             vld_q, vld_d;
    logic [WW-1:0]    win_q, win_d;
    logic [COL_W-1:0] ocol_q, ocol_d;
    logic             olast_q, olast_d;
    logic             out_free;
    logic             accept;
`ifdef CONV_WINDOW_ZERO_PAD_EN
    logic [FW-1:0]    flush_q, flush_d;
`endif

    // Column register after one shift, repacked into the (line, column) output layout.
    always_comb begin
        shift_in = in_data;
`ifdef CONV_WINDOW_ZERO_PAD_EN
        if (state_q == S_FLUSH) shift_in = '0;
`endif
        for (int c = 0; c < KERNEL_W - 1; c++) shifted[c] = col_q[c+1];
        shifted[KERNEL_W-1] = shift_in;
        win_shift = '0;
        for (int l = 0; l < NUM_LINES; l++) begin
            for (int c = 0; c < KERNEL_W; c++) begin
                win_shift[(l*KERNEL_W + c)*DATA_WIDTH +: DATA_WIDTH] = shifted[c][l*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        col_idx_d = col_idx_q;
        col_d     = col_q;
        vld_d     = vld_q;
        win_d     = win_q;
        ocol_d    = ocol_q;
        olast_d   = olast_q;
`ifdef CONV_WINDOW_ZERO_PAD_EN
        flush_d   = flush_q;
`endif
        out_free = !vld_q || out_ready;
`ifdef CONV_WINDOW_ZERO_PAD_EN
        in_ready = out_free && (state_q != S_FLUSH);
`else
        in_ready = out_free;
`endif
        accept = in_valid && in_ready;

        if (vld_q && out_ready) vld_d = 1'b0;

        if (accept) begin
            col_d     = shifted;
            col_idx_d = col_idx_q + COL_W'(1);
            if (fill_q == FILL_FULL) begin
                vld_d  = 1'b1;
                win_d  = win_shift;
                ocol_d = col_idx_q - COL_OFF;
`ifdef CONV_WINDOW_ZERO_PAD_EN
                olast_d = (P == 0) ? in_last : 1'b0;
`else
                olast_d = in_last;
`endif
            end else begin
                fill_d = fill_q + FW'(1);
                if (fill_q + FW'(1) == FILL_FULL) state_d = S_STREAM;
            end
            // A row end restarts the fill so the next row never sees these columns.
            if (in_last) begin
`ifdef CONV_WINDOW_ZERO_PAD_EN
                if (P > 0) begin
                    state_d = S_FLUSH;
                    flush_d = FW'(P);
                end else begin
                    state_d   = S_FILL;
                    fill_d    = FILL_INIT;
                    col_idx_d = '0;
                    for (int c = 0; c < KERNEL_W; c++) col_d[c] = '0;
                end
`else
                state_d   = S_FILL;
                fill_d    = FILL_INIT;
                col_idx_d = '0;
`endif
            end
        end
`ifdef CONV_WINDOW_ZERO_PAD_EN
        // Flush steps shift in zero columns; windows centred before column 0 are suppressed.
        else if (state_q == S_FLUSH && out_free) begin
            col_d     = shifted;
            col_idx_d = col_idx_q + COL_W'(1);
            flush_d   = flush_q - FW'(1);
            if (col_idx_q >= COL_OFF) begin
                vld_d   = 1'b1;
                win_d   = win_shift;
                ocol_d  = col_idx_q - COL_OFF;
                olast_d = (flush_q == FW'(1));
            end
            if (flush_q == FW'(1)) begin
                state_d   = S_FILL;
                fill_d    = FILL_INIT;
                col_idx_d = '0;
                for (int c = 0; c < KERNEL_W; c++) col_d[c] = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FILL;
            fill_q    <= FILL_INIT;
            col_idx_q <= '0;
            for (int c = 0; c < KERNEL_W; c++) col_q[c] <= '0;
            vld_q     <= 1'b0;
            win_q     <= '0;
            ocol_q    <= '0;
            olast_q   <= 1'b0;
`ifdef CONV_WINDOW_ZERO_PAD_EN
            flush_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            col_idx_q <= col_idx_d;
            col_q     <= col_d;
            vld_q     <= vld_d;
            win_q     <= win_d;
            ocol_q    <= ocol_d;
            olast_q   <= olast_d;
`ifdef CONV_WINDOW_ZERO_PAD_EN
            flush_q   <= flush_d;
`endif
        end
    end

    assign out_valid  = vld_q;
    assign out_window = win_q;
    assign out_col    = ocol_q;
    assign out_last   = olast_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed self-checking bench for conv_window_gen (3x3 window, 16-bit pixels).
// Build with CONV_WINDOW_ZERO_PAD_EN defined to exercise the padded variant instead.
module tb_conv_window_gen;

    localparam int NL = 3;
    localparam int K  = 3;
    localparam int DW = 16;
    localparam int CWD = 14;
    localparam int CW = NL * DW;
    localparam int WW = NL * K * DW;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [CW-1:0]  in_data;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [WW-1:0]  out_window;
    logic [CWD-1:0] out_col;
    logic           out_last;

    conv_window_gen #(.NUM_LINES(NL), .KERNEL_W(K), .DATA_WIDTH(DW), .COL_W(CWD)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
        .out_col(out_col), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] win;
        int            col;
        bit            last;
        int            cyc;
    } rec_t;

    rec_t q[$];
    int   cyc = 0;
    int   stall_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only change just after posedge, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        rec_t r;
        if (out_valid && out_ready) begin
            r.win  = out_window;
            r.col  = int'(out_col);
            r.last = out_last;
            r.cyc  = cyc;
            q.push_back(r);
        end
        if (in_valid && !in_ready) stall_cnt++;
    end

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] col_data(input int v);
        logic [CW-1:0] d;
        for (int l = 0; l < NL; l++) d[l*DW +: DW] = DW'(16*l + v);
        return d;
    endfunction

    function automatic logic [WW-1:0] exp_win(input int v0);
        logic [WW-1:0] w;
        for (int l = 0; l < NL; l++)
            for (int c = 0; c < K; c++) w[(l*K + c)*DW +: DW] = DW'(16*l + v0 + c);
        return w;
    endfunction

    function automatic logic [WW-1:0] exp_pad(input int k, input int width);
        logic [WW-1:0] w;
        int src;
        for (int l = 0; l < NL; l++)
            for (int c = 0; c < K; c++) begin
                src = k - 1 + c;
                w[(l*K + c)*DW +: DW] = (src < 0 || src >= width) ? DW'(0) : DW'(16*l + src);
            end
        return w;
    endfunction

    task automatic drive(input logic [CW-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
    endtask

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) check("accept_timeout", 256'(0), 256'(1));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_out_last", 256'(out_last), 256'(0));
        check("rst_out_col", 256'(out_col), 256'(0));
        check("rst_out_window", 256'(out_window), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));

`ifdef CONV_WINDOW_ZERO_PAD_EN
        // Padded row of width 4: four windows centred on columns 0..3.
        q.delete();
        for (int c = 0; c < 4; c++) begin
            drive(col_data(c), c == 3);
            wait_accept();
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("pad_flush_in_ready", 256'(in_ready), 256'(0));
        @(posedge clk); #1;
        check("pad_after_flush_in_ready", 256'(in_ready), 256'(1));
        idle(3);
        check("pad_count", 256'(q.size()), 256'(4));
        if (q.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("pad_col%0d", k), 256'(q[k].col), 256'(k));
                check($sformatf("pad_win%0d", k), 256'(q[k].win), 256'(exp_pad(k, 4)));
                check($sformatf("pad_last%0d", k), 256'(q[k].last), 256'(k == 3));
            end
            check("pad_first_col0_zero", 256'({q[0].win[6*DW +: DW], q[0].win[3*DW +: DW], q[0].win[0 +: DW]}), 256'(0));
            check("pad_last_col2_zero", 256'({q[3].win[8*DW +: DW], q[3].win[5*DW +: DW], q[3].win[2*DW +: DW]}), 256'(0));
        end
`else
        // Row of width 5: three consecutive windows, columns 0..2.
        q.delete();
        for (int c = 0; c < 5; c++) begin
            drive(col_data(c), c == 4);
            wait_accept();
        end
        idle(4);
        check("row5_count", 256'(q.size()), 256'(3));
        if (q.size() == 3) begin
            check("row5_first_literal", 256'(q[0].win),
                  256'(144'h0022_0021_0020_0012_0011_0010_0002_0001_0000));
            for (int i = 0; i < 3; i++) begin
                check($sformatf("row5_col%0d", i), 256'(q[i].col), 256'(i));
                check($sformatf("row5_win%0d", i), 256'(q[i].win), 256'(exp_win(i)));
                check($sformatf("row5_last%0d", i), 256'(q[i].last), 256'(i == 2));
            end
            check("row5_consec1", 256'(q[1].cyc - q[0].cyc), 256'(1));
            check("row5_consec2", 256'(q[2].cyc - q[1].cyc), 256'(1));
        end

        // Backpressure: window held for 4 cycles with out_ready low.
        q.delete();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(col_data(200 + c), 1'b0);
            wait_accept();
        end
        drive(col_data(203), 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_out_valid", 256'(out_valid), 256'(1));
            check("bp_out_col", 256'(out_col), 256'(0));
            check("bp_out_window", 256'(out_window), 256'(exp_win(200)));
            check("bp_in_ready", 256'(in_ready), 256'(0));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_accept();
        idle(3);
        check("bp_count", 256'(q.size()), 256'(2));
        if (q.size() == 2) begin
            check("bp_w0_win", 256'(q[0].win), 256'(exp_win(200)));
            check("bp_w0_col", 256'(q[0].col), 256'(0));
            check("bp_w0_last", 256'(q[0].last), 256'(0));
            check("bp_w1_win", 256'(q[1].win), 256'(exp_win(201)));
            check("bp_w1_col", 256'(q[1].col), 256'(1));
            check("bp_w1_last", 256'(q[1].last), 256'(1));
        end

        // Short row of width 2, then a row of width 3.
        q.delete();
        drive(col_data(300), 1'b0); wait_accept();
        drive(col_data(301), 1'b1); wait_accept();
        for (int c = 0; c < 3; c++) begin
            drive(col_data(400 + c), c == 2);
            wait_accept();
        end
        idle(3);
        check("short_count", 256'(q.size()), 256'(1));
        if (q.size() == 1) begin
            check("short_win", 256'(q[0].win), 256'(exp_win(400)));
            check("short_col", 256'(q[0].col), 256'(0));
            check("short_last", 256'(q[0].last), 256'(1));
        end

        // Reset one cycle after two accepted columns.
        q.delete();
        drive(col_data(500), 1'b0); wait_accept();
        drive(col_data(501), 1'b0); wait_accept();
        idle(1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_out_valid", 256'(out_valid), 256'(0));
        check("mid_rst_in_ready", 256'(in_ready), 256'(1));
        drive(col_data(600), 1'b0); wait_accept();
        check("mid_rst_c0_valid", 256'(out_valid), 256'(0));
        drive(col_data(601), 1'b0); wait_accept();
        check("mid_rst_c1_valid", 256'(out_valid), 256'(0));
        drive(col_data(602), 1'b1); wait_accept();
        check("mid_rst_c2_valid", 256'(out_valid), 256'(1));
        check("mid_rst_c2_col", 256'(out_col), 256'(0));
        check("mid_rst_c2_win", 256'(out_window), 256'(exp_win(600)));
        idle(2);
        check("mid_rst_count", 256'(q.size()), 256'(1));

        // Continuous 100-column row.
        q.delete();
        stall_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            drive(col_data(1000 + c), c == 99);
            wait_accept();
        end
        idle(3);
        check("long_count", 256'(q.size()), 256'(98));
        check("long_stalls", 256'(stall_cnt), 256'(0));
        if (q.size() == 98) begin
            for (int i = 0; i < 98; i++) begin
                check($sformatf("long_col%0d", i), 256'(q[i].col), 256'(i));
                check($sformatf("long_win%0d", i), 256'(q[i].win), 256'(exp_win(1000 + i)));
                check($sformatf("long_cyc%0d", i), 256'(q[i].cyc - q[0].cyc), 256'(i));
                check($sformatf("long_last%0d", i), 256'(q[i].last), 256'(i == 97));
            end
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
